// File: rtl/demux_bus_dispatch.sv
// Credit-gated, in-order dispatch stage feeding demux_bus: buffers (dest, data) beats
// and issues the FIFO head only when its destination lane still holds a credit.
module demux_bus_dispatch #(
    parameter int DATA_WIDTH   = 32,
    parameter int BUS_WIDTH    = 8,
    parameter int SEL_WIDTH    = $clog2(BUS_WIDTH),
    parameter int FIFO_DEPTH   = 4,
    parameter int LANE_CREDITS = 4,
    parameter int CREDIT_WIDTH = $clog2(LANE_CREDITS + 1)
) (
    input  logic                             ap_clk,
    input  logic                             areset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DATA_WIDTH-1:0]            in_data,
    input  logic [SEL_WIDTH-1:0]             in_dest,
    input  logic [BUS_WIDTH-1:0]             credit_return,
    output logic [SEL_WIDTH-1:0]             sel_out,
    output logic [DATA_WIDTH-1:0]            data_out,
    output logic [BUS_WIDTH-1:0]             data_out_valid,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count,
    output logic                             dest_error,
    output logic                             credit_overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CREDIT_WIDTH-1:0] CREDIT_MAX = CREDIT_WIDTH'(LANE_CREDITS);
    localparam logic [CNT_W-1:0]        CNT_FULL   = CNT_W'(FIFO_DEPTH);

    // Saturating credit update: issue and return on the same lane cancel out.
    function automatic logic [CREDIT_WIDTH-1:0] credit_next(
        input logic [CREDIT_WIDTH-1:0] cur,
        input logic                    iss,
        input logic                    ret
    );
        if (iss && !ret)
            return cur - 1'b1;
        if (ret && !iss && (cur != CREDIT_MAX))
            return cur + 1'b1;
        return cur;
    endfunction

    logic [SEL_WIDTH-1:0]    mem_dest [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]   mem_data [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [CNT_W-1:0]        count_p0;
    logic [CREDIT_WIDTH-1:0] credit [BUS_WIDTH];

    logic                    push;
    logic                    dest_ok;
    logic                    wr_en;
    logic                    nonempty;
    logic                    pop;
    logic [SEL_WIDTH-1:0]    head_dest;
    logic [DATA_WIDTH-1:0]   head_data;
    logic [BUS_WIDTH-1:0]    lane_hit;
    logic [BUS_WIDTH-1:0]    issue_vec;
    logic [BUS_WIDTH-1:0]    ovf_vec;

    logic [SEL_WIDTH-1:0]    sel_p1;
    logic [DATA_WIDTH-1:0]   data_p1;
    logic [BUS_WIDTH-1:0]    vld_p1;
    logic                    dest_err_q;
    logic                    ovf_q;

    // Ready depends only on registered occupancy (and reset), never on this cycle's pop.
    assign in_ready = ~areset & (count_p0 < CNT_FULL);
    assign push     = in_valid & in_ready;
    assign wr_en    = push & dest_ok;

    generate
        if (BUS_WIDTH == (1 << SEL_WIDTH)) begin : g_dest_full
            assign dest_ok = 1'b1;
        end else begin : g_dest_chk
            assign dest_ok = ({1'b0, in_dest} < (SEL_WIDTH + 1)'(BUS_WIDTH));
        end
    endgenerate

    // ---- stage p0: FIFO head and issue decision ----
    assign head_dest = mem_dest[rd_ptr];
    assign head_data = mem_data[rd_ptr];
    assign nonempty  = (count_p0 != '0);

    for (genvar i = 0; i < BUS_WIDTH; i++) begin : g_lane
        assign lane_hit[i]  = (head_dest == SEL_WIDTH'(i)) && (credit[i] != '0);
        assign issue_vec[i] = nonempty & lane_hit[i];
        assign ovf_vec[i]   = credit_return[i] & ~issue_vec[i] & (credit[i] == CREDIT_MAX);
    end

    assign pop = |issue_vec;

    always_ff @(posedge ap_clk) begin
        if (wr_en) begin
            mem_dest[wr_ptr] <= in_dest;
            mem_data[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_p0   <= '0;
            dest_err_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count_p0 <= count_p0 + CNT_W'(wr_en) - CNT_W'(pop);
            if (push && !dest_ok)
                dest_err_q <= 1'b1;
            if (|ovf_vec)
                ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge ap_clk) begin
        for (int l = 0; l < BUS_WIDTH; l++) begin
            if (areset)
                credit[l] <= CREDIT_MAX;
            else
                credit[l] <= credit_next(credit[l], issue_vec[l], credit_return[l]);
        end
    end

    // ---- stage p1: registered issue towards the demux ----
    always_ff @(posedge ap_clk) begin
        if (areset) begin
            vld_p1  <= '0;
            sel_p1  <= '0;
            data_p1 <= '0;
        end else begin
            vld_p1 <= issue_vec;
            if (pop) begin
                sel_p1  <= head_dest;
                data_p1 <= head_data;
            end
        end
    end

    assign sel_out         = sel_p1;
    assign data_out        = data_p1;
    assign data_out_valid  = vld_p1;
    assign fifo_count      = count_p0;
    assign dest_error      = dest_err_q;
    assign credit_overflow = ovf_q;

endmodule

// File: tb/tb_demux_bus_dispatch.sv
// Bench for demux_bus_dispatch: directed vector table, corner-case sequences and
// randomized traffic against a queue-based reference model.
module tb_demux_bus_dispatch;

    logic        ap_clk = 1'b0;
    logic        areset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [2:0]  in_dest = '0;
    logic [7:0]  credit_return = '0;
    logic [2:0]  sel_out;
    logic [31:0] data_out;
    logic [7:0]  data_out_valid;
    logic [2:0]  fifo_count;
    logic        dest_error;
    logic        credit_overflow;

    logic        in_valid6 = 1'b0;
    logic        in_ready6;
    logic [31:0] in_data6 = '0;
    logic [2:0]  in_dest6 = '0;
    logic [5:0]  credit_return6 = '0;
    logic [2:0]  sel_out6;
    logic [31:0] data_out6;
    logic [5:0]  data_out_valid6;
    logic [2:0]  fifo_count6;
    logic        dest_error6;
    logic        credit_overflow6;

    always #5 ap_clk = ~ap_clk;

    demux_bus_dispatch dut (
        .ap_clk(ap_clk), .areset(areset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_dest(in_dest), .credit_return(credit_return),
        .sel_out(sel_out), .data_out(data_out), .data_out_valid(data_out_valid),
        .fifo_count(fifo_count), .dest_error(dest_error), .credit_overflow(credit_overflow)
    );

    demux_bus_dispatch #(.BUS_WIDTH(6)) dut6 (
        .ap_clk(ap_clk), .areset(areset), .in_valid(in_valid6), .in_ready(in_ready6),
        .in_data(in_data6), .in_dest(in_dest6), .credit_return(credit_return6),
        .sel_out(sel_out6), .data_out(data_out6), .data_out_valid(data_out_valid6),
        .fifo_count(fifo_count6), .dest_error(dest_error6), .credit_overflow(credit_overflow6)
    );

    typedef struct {
        int          dest;
        logic [31:0] data;
    } beat_t;

    typedef struct {
        logic        rst;
        logic        vld;
        logic [2:0]  dest;
        logic [31:0] data;
        logic [7:0]  cret;
        logic        e_ready;
        int          e_count;
        logic [7:0]  e_valid;
        logic [2:0]  e_sel;
        logic [31:0] e_data;
    } vec_t;

    int checks = 0;
    int errors = 0;

    beat_t       mq[$];
    int          mcred[8];
    logic [7:0]  mvalid = '0;
    logic [2:0]  msel = '0;
    logic [31:0] mdata = '0;
    logic        mderr = 1'b0;
    logic        movf = 1'b0;
    logic        macc = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: lanes hold integer credit counts, the FIFO is a queue of beats.
    task automatic model_step();
        bit iss;
        int hd;
        int n;
        if (areset) begin
            mq.delete();
            for (int l = 0; l < 8; l++) mcred[l] = 4;
            mvalid = '0; msel = '0; mdata = '0; mderr = 1'b0; movf = 1'b0; macc = 1'b0;
        end else begin
            iss = 1'b0;
            hd  = 0;
            if (mq.size() > 0) begin
                hd  = mq[0].dest;
                iss = (mcred[hd] > 0);
            end
            macc = in_valid && (mq.size() < 4);
            for (int l = 0; l < 8; l++) begin
                n = mcred[l] - ((iss && hd == l) ? 1 : 0) + (credit_return[l] ? 1 : 0);
                if (n > 4) begin
                    n = 4;
                    movf = 1'b1;
                end
                mcred[l] = n;
            end
            if (iss) begin
                mvalid = 8'(1 << hd);
                msel   = 3'(hd);
                mdata  = mq[0].data;
                void'(mq.pop_front());
            end else begin
                mvalid = '0;
            end
            if (macc) begin
                if (int'(in_dest) < 8) mq.push_back('{dest: int'(in_dest), data: in_data});
                else mderr = 1'b1;
            end
        end
    endtask

    task automatic cycle();
        @(posedge ap_clk);
        model_step();
        #1;
        chk("in_ready", in_ready, (!areset && mq.size() < 4));
        chk("fifo_count", fifo_count, mq.size());
        chk("data_out_valid", data_out_valid, mvalid);
        chk("sel_out", sel_out, msel);
        chk("data_out", data_out, mdata);
        chk("dest_error", dest_error, mderr);
        chk("credit_overflow", credit_overflow, movf);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        credit_return = '0;
    endtask

    task automatic push(input int dest, input logic [31:0] data);
        in_valid = 1'b1;
        in_dest = 3'(dest);
        in_data = data;
        credit_return = '0;
    endtask

    task automatic do_reset();
        idle();
        in_valid6 = 1'b0;
        areset = 1'b1;
        cycle();
        areset = 1'b0;
    endtask

    function automatic vec_t mk(logic rst, logic vld, logic [2:0] dest, logic [31:0] data,
                                logic [7:0] cret, logic e_ready, int e_count,
                                logic [7:0] e_valid, logic [2:0] e_sel, logic [31:0] e_data);
        vec_t v;
        v.rst = rst; v.vld = vld; v.dest = dest; v.data = data; v.cret = cret;
        v.e_ready = e_ready; v.e_count = e_count; v.e_valid = e_valid;
        v.e_sel = e_sel; v.e_data = e_data;
        return v;
    endfunction

    initial begin
        vec_t tbl[18];
        int   cnt;

        // Reset, single beat to lane 3, then six beats to lane 2 exhausting its credits.
        tbl[0]  = mk(1, 0, 0, 32'h0,         8'h00, 0, 0, 8'h00, 0, 32'h0);
        tbl[1]  = mk(0, 0, 0, 32'h0,         8'h00, 1, 0, 8'h00, 0, 32'h0);
        tbl[2]  = mk(0, 1, 3, 32'hA5A5_0001, 8'h00, 1, 1, 8'h00, 0, 32'h0);
        tbl[3]  = mk(0, 0, 0, 32'h0,         8'h00, 1, 0, 8'h08, 3, 32'hA5A5_0001);
        tbl[4]  = mk(0, 0, 0, 32'h0,         8'h00, 1, 0, 8'h00, 3, 32'hA5A5_0001);
        tbl[5]  = mk(0, 1, 2, 32'h200,       8'h00, 1, 1, 8'h00, 3, 32'hA5A5_0001);
        tbl[6]  = mk(0, 1, 2, 32'h201,       8'h00, 1, 1, 8'h04, 2, 32'h200);
        tbl[7]  = mk(0, 1, 2, 32'h202,       8'h00, 1, 1, 8'h04, 2, 32'h201);
        tbl[8]  = mk(0, 1, 2, 32'h203,       8'h00, 1, 1, 8'h04, 2, 32'h202);
        tbl[9]  = mk(0, 1, 2, 32'h204,       8'h00, 1, 1, 8'h04, 2, 32'h203);
        tbl[10] = mk(0, 1, 2, 32'h205,       8'h00, 1, 2, 8'h00, 2, 32'h203);
        tbl[11] = mk(0, 0, 0, 32'h0,         8'h00, 1, 2, 8'h00, 2, 32'h203);
        tbl[12] = mk(0, 0, 0, 32'h0,         8'h04, 1, 2, 8'h00, 2, 32'h203);
        tbl[13] = mk(0, 0, 0, 32'h0,         8'h00, 1, 1, 8'h04, 2, 32'h204);
        tbl[14] = mk(0, 0, 0, 32'h0,         8'h00, 1, 1, 8'h00, 2, 32'h204);
        tbl[15] = mk(0, 0, 0, 32'h0,         8'h04, 1, 1, 8'h00, 2, 32'h204);
        tbl[16] = mk(0, 0, 0, 32'h0,         8'h00, 1, 0, 8'h04, 2, 32'h205);
        tbl[17] = mk(0, 0, 0, 32'h0,         8'h00, 1, 0, 8'h00, 2, 32'h205);

        for (int i = 0; i < 18; i++) begin
            areset = tbl[i].rst;
            in_valid = tbl[i].vld;
            in_dest = tbl[i].dest;
            in_data = tbl[i].data;
            credit_return = tbl[i].cret;
            cycle();
            chk($sformatf("row%0d_ready", i), in_ready, tbl[i].e_ready);
            chk($sformatf("row%0d_count", i), fifo_count, tbl[i].e_count);
            chk($sformatf("row%0d_valid", i), data_out_valid, tbl[i].e_valid);
            chk($sformatf("row%0d_sel", i), sel_out, tbl[i].e_sel);
            chk($sformatf("row%0d_data", i), data_out, tbl[i].e_data);
        end

        // Issue and return on lane 5 in the same cycle with one credit left.
        do_reset();
        push(5, 32'h500); cycle();
        push(5, 32'h501); cycle();
        push(5, 32'h502); cycle();
        push(5, 32'h5A0); cycle();
        push(5, 32'h5B0); credit_return = 8'h20; cycle();
        chk("simul_a_valid", data_out_valid, 8'h20);
        chk("simul_a_data", data_out, 32'h5A0);
        idle(); cycle();
        chk("simul_b_valid", data_out_valid, 8'h20);
        chk("simul_b_data", data_out, 32'h5B0);
        cycle();

        // Backpressure on a lane with no credits.
        do_reset();
        for (int i = 0; i < 4; i++) begin push(0, 32'h10 + i); cycle(); end
        idle(); cycle(); cycle();
        for (int i = 0; i < 4; i++) begin push(0, 32'h100 + i); cycle(); end
        chk("bp_ready_low", in_ready, 1'b0);
        chk("bp_full", fifo_count, 3'd4);
        push(0, 32'h104); cycle();
        chk("bp_held_count", fifo_count, 3'd4);
        credit_return = 8'h01; cycle();
        chk("bp_ready_after_ret", in_ready, 1'b0);
        credit_return = 8'h00; cycle();
        chk("bp_issue_valid", data_out_valid, 8'h01);
        chk("bp_issue_data", data_out, 32'h100);
        chk("bp_ready_up", in_ready, 1'b1);
        cycle();
        chk("bp_fifth_accepted", fifo_count, 3'd4);
        idle(); cycle();

        // Reset mid-operation restores lane credits and flushes the FIFO.
        do_reset();
        for (int i = 0; i < 4; i++) begin push(1, 32'h300 + i); cycle(); end
        idle(); cycle(); cycle();
        for (int i = 0; i < 3; i++) begin push(1, 32'h310 + i); cycle(); end
        idle();
        chk("mid_fill", fifo_count, 3'd3);
        areset = 1'b1; cycle();
        chk("mid_rst_count", fifo_count, 3'd0);
        chk("mid_rst_valid", data_out_valid, 8'h00);
        areset = 1'b0; cycle();
        chk("mid_ready", in_ready, 1'b1);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) push(1, 32'h320 + i); else idle();
            cycle();
            if (data_out_valid == 8'h02) cnt++;
        end
        chk("mid_credits_restored", cnt, 4);

        // Return to a full lane sets the sticky overflow and leaves credits at 4.
        do_reset();
        credit_return = 8'h80; cycle();
        chk("ovf_set", credit_overflow, 1'b1);
        idle(); cycle(); cycle();
        chk("ovf_sticky", credit_overflow, 1'b1);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (i < 5) push(7, 32'h700 + i); else idle();
            cycle();
            if (data_out_valid == 8'h80) cnt++;
        end
        chk("ovf_credit_issues", cnt, 4);
        chk("ovf_blocked", fifo_count, 3'd1);

        // Out-of-range destination on a 6-lane instance.
        do_reset();
        in_valid6 = 1'b1; in_dest6 = 3'd6; in_data6 = 32'h66; cycle();
        chk("derr_set", dest_error6, 1'b1);
        chk("derr_count", fifo_count6, 3'd0);
        chk("derr_no_issue", data_out_valid6, 6'h00);
        in_valid6 = 1'b0; cycle();
        chk("derr_sticky", dest_error6, 1'b1);
        chk("derr_no_issue2", data_out_valid6, 6'h00);
        in_valid6 = 1'b1; in_dest6 = 3'd5; in_data6 = 32'h55; cycle();
        chk("six_push", fifo_count6, 3'd1);
        in_valid6 = 1'b0; cycle();
        chk("six_issue_valid", data_out_valid6, 6'h20);
        chk("six_issue_data", data_out6, 32'h55);

        // Randomized traffic with sparse credit returns and occasional resets.
        do_reset();
        for (int i = 0; i < 800; i++) begin
            areset = ($urandom_range(0, 79) == 0);
            in_valid = 1'($urandom_range(0, 3) != 0);
            in_dest = 3'($urandom_range(0, 7));
            in_data = $urandom;
            credit_return = 8'($urandom & $urandom & $urandom);
            cycle();
        end
        idle(); areset = 1'b0; cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
